// File: rtl/conv_pkg.sv
// Shared constants, state encoding and index helper for the 3x3 valid convolution controller.
package conv_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned IN_DIM   = 4;
    localparam int unsigned K_DIM    = 3;
    localparam int unsigned ACC_W    = 20;
    localparam int unsigned OUT_DIM  = IN_DIM - K_DIM + 1;
    localparam int unsigned TAPS     = K_DIM * K_DIM;
    localparam int unsigned NPOS     = OUT_DIM * OUT_DIM;
    localparam int unsigned IN_SEL_W = $clog2(IN_DIM * IN_DIM);
    localparam int unsigned TAP_W    = $clog2(TAPS);
    localparam int unsigned POS_W    = $clog2(NPOS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Input-tile index of filter tap 'tap' while computing output position 'pos'.
    function automatic logic [IN_SEL_W-1:0] in_index(input logic [POS_W-1:0] pos,
                                                     input logic [TAP_W-1:0] tap);
        int unsigned tr;
        int unsigned tc;
        int unsigned oy;
        int unsigned ox;
        tr = 32'(tap) / K_DIM;
        tc = 32'(tap) % K_DIM;
        oy = 32'(pos) / OUT_DIM;
        ox = 32'(pos) % OUT_DIM;
        return IN_SEL_W'((oy + tr) * IN_DIM + (ox + tc));
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered unsigned multiply-accumulate; clear has priority over enable.
module conv_mac #(
    parameter int unsigned A_W   = 8,
    parameter int unsigned ACC_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    output logic [ACC_W-1:0] acc
);

    localparam int unsigned PROD_W = 2 * A_W;

    logic [PROD_W-1:0] w_prod;

    assign w_prod = PROD_W'(a) * PROD_W'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/conv_controller.sv
// Sequences a 3x3 valid convolution over the 4x4 tile, one tap per cycle,
// and hands each of the four results downstream with valid/ready.
module conv_controller
    import conv_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   pix_data,
    input  logic [DATA_W-1:0]   flt_data,
    input  logic                out_ready,
    output logic [IN_SEL_W-1:0] in_sel,
    output logic [TAP_W-1:0]    flt_sel,
    output logic [ACC_W-1:0]    result,
    output logic [POS_W-1:0]    out_idx,
    output logic                out_valid,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    state_t             r_state;
    logic [POS_W-1:0]   r_pos;
    logic [TAP_W-1:0]   r_tap;
    logic [ACC_W-1:0]   r_result;
    logic [POS_W-1:0]   r_out_idx;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [POS_W-1:0]   w_pos_nxt;
    logic [TAP_W-1:0]   w_tap_nxt;
    logic [ACC_W-1:0]   w_result_nxt;
    logic [POS_W-1:0]   w_out_idx_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_in_mac;
    logic [ACC_W-1:0]   w_acc;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_sum;

    assign w_in_mac = (r_state == ST_MAC);

    // Accumulator is held at zero outside MAC, so every position starts clean.
    conv_mac #(
        .A_W   (DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (!w_in_mac),
        .en  (w_in_mac),
        .a   (pix_data),
        .b   (flt_data),
        .acc (w_acc)
    );

    // The last tap's product has not reached the accumulator yet; fold it in here.
    assign w_prod = PROD_W'(pix_data) * PROD_W'(flt_data);
    assign w_sum  = w_acc + ACC_W'(w_prod);

    assign in_sel    = w_in_mac ? in_index(r_pos, r_tap) : '0;
    assign flt_sel   = w_in_mac ? r_tap : '0;
    assign result    = r_result;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pos       <= '0;
            r_tap       <= '0;
            r_result    <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pos       <= w_pos_nxt;
            r_tap       <= w_tap_nxt;
            r_result    <= w_result_nxt;
            r_out_idx   <= w_out_idx_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_pos_nxt       = r_pos;
        w_tap_nxt       = r_tap;
        w_result_nxt    = r_result;
        w_out_idx_nxt   = r_out_idx;
        w_out_valid_nxt = r_out_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_MAC;
                    w_pos_nxt   = '0;
                    w_tap_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_MAC: begin
                if (r_tap == TAP_W'(TAPS - 1)) begin
                    w_result_nxt    = w_sum;
                    w_out_idx_nxt   = r_pos;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = ST_OUT;
                end else begin
                    w_tap_nxt = r_tap + TAP_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_tap_nxt       = '0;
                    if (r_pos == POS_W'(NPOS - 1)) begin
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pos_nxt   = r_pos + POS_W'(1);
                        w_state_nxt = ST_MAC;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
